// File: rtl/reorder_buffer_if.sv
// Dispatch / complete / retire / rollback bundle between the core and the reorder buffer.
interface reorder_buffer_if #(
   parameter int unsigned NUM_ROB  = 8,
   parameter int unsigned PR_W     = 6,
   parameter int unsigned FL_IDX_W = 5
);
   localparam int unsigned IDX_W = $clog2(NUM_ROB);

   logic                     dispatch_en;
   logic [1:0]               dispatch_valid;
   logic [1:0][PR_W-1:0]     dispatch_T_idx;
   logic [1:0][PR_W-1:0]     dispatch_Told_idx;
   logic [1:0][FL_IDX_W-1:0] dispatch_FL_idx;
   logic [1:0]               complete_en;
   logic [1:0][IDX_W-1:0]    complete_rob_idx;
   logic                     rollback_en;
   logic [IDX_W-1:0]         rollback_rob_idx;

   logic                     ROB_valid;
   logic [1:0][IDX_W-1:0]    ROB_idx;
   logic [1:0]               retire_en;
   logic [1:0][PR_W-1:0]     retire_T_idx;
   logic [1:0][PR_W-1:0]     retire_Told_idx;
   logic [FL_IDX_W-1:0]      FL_rollback_idx;
   logic                     empty;

   modport master (
      output dispatch_en, dispatch_valid, dispatch_T_idx, dispatch_Told_idx, dispatch_FL_idx,
      output complete_en, complete_rob_idx, rollback_en, rollback_rob_idx,
      input  ROB_valid, ROB_idx, retire_en, retire_T_idx, retire_Told_idx, FL_rollback_idx, empty
   );

   modport slave (
      input  dispatch_en, dispatch_valid, dispatch_T_idx, dispatch_Told_idx, dispatch_FL_idx,
      input  complete_en, complete_rob_idx, rollback_en, rollback_rob_idx,
      output ROB_valid, ROB_idx, retire_en, retire_T_idx, retire_Told_idx, FL_rollback_idx, empty
   );
endinterface

// File: rtl/reorder_buffer.sv
// Two-wide circular reorder buffer: in-order allocate, out-of-order complete,
// in-order retire of up to two entries, and free-list rollback on mispredict.
module reorder_buffer #(
   parameter int unsigned NUM_ROB  = 8,
   parameter int unsigned PR_W     = 6,
   parameter int unsigned FL_IDX_W = 5,
   parameter int unsigned ZERO_PR  = 31
) (
   input logic             clock,
   input logic             reset,
   reorder_buffer_if.slave rob
);
   localparam int unsigned IDX_W = $clog2(NUM_ROB);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam logic [PR_W-1:0] ZERO_TAG = PR_W'(ZERO_PR);

   logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [NUM_ROB-1:0]  valid_q, valid_d, complete_q, complete_d;
   logic [PR_W-1:0]     t_q    [NUM_ROB];
   logic [PR_W-1:0]     t_d    [NUM_ROB];
   logic [PR_W-1:0]     told_q [NUM_ROB];
   logic [PR_W-1:0]     told_d [NUM_ROB];
   logic [FL_IDX_W-1:0] fl_q   [NUM_ROB];
   logic [FL_IDX_W-1:0] fl_d   [NUM_ROB];

   logic [IDX_W-1:0]      head_p1;
   logic [1:0]            retire_c;
   logic [1:0]            n_ret, n_disp;
   logic                  rob_valid_c, disp_fire;
   logic [1:0][IDX_W-1:0] slot_idx;
   logic [IDX_W-1:0]      dist_rb, dist_i;

   // Retire selection, slot packing and dispatch qualification from registered state
   always_comb begin
      head_p1     = head_q + IDX_W'(1);
      retire_c    = '0;
      retire_c[0] = valid_q[head_q] & complete_q[head_q];
      retire_c[1] = retire_c[0] & valid_q[head_p1] & complete_q[head_p1];
      n_ret       = {1'b0, retire_c[0]} + {1'b0, retire_c[1]};
      rob_valid_c = (count_q <= CNT_W'(NUM_ROB - 2));
      slot_idx[0] = tail_q;
      slot_idx[1] = tail_q + IDX_W'(rob.dispatch_valid[0]);
      disp_fire   = rob.dispatch_en & rob_valid_c & ~rob.rollback_en;
      n_disp      = disp_fire ? ({1'b0, rob.dispatch_valid[0]} + {1'b0, rob.dispatch_valid[1]}) : 2'd0;
   end

   assign rob.ROB_valid          = rob_valid_c;
   assign rob.empty              = (count_q == '0);
   assign rob.ROB_idx            = slot_idx;
   assign rob.retire_en          = retire_c;
   assign rob.retire_T_idx[0]    = retire_c[0] ? t_q[head_q]     : ZERO_TAG;
   assign rob.retire_T_idx[1]    = retire_c[1] ? t_q[head_p1]    : ZERO_TAG;
   assign rob.retire_Told_idx[0] = retire_c[0] ? told_q[head_q]  : ZERO_TAG;
   assign rob.retire_Told_idx[1] = retire_c[1] ? told_q[head_p1] : ZERO_TAG;
   assign rob.FL_rollback_idx    = fl_q[rob.rollback_rob_idx];

   // Next-state: complete, retire, dispatch, then rollback overrides pointers and squashes
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      valid_d    = valid_q;
      complete_d = complete_q;
      t_d        = t_q;
      told_d     = told_q;
      fl_d       = fl_q;
      dist_rb    = rob.rollback_rob_idx - head_q;
      dist_i     = '0;

      for (int p = 0; p < 2; p++) begin
         if (rob.complete_en[p] && valid_q[rob.complete_rob_idx[p]])
            complete_d[rob.complete_rob_idx[p]] = 1'b1;
      end

      if (retire_c[0]) begin
         valid_d[head_q]    = 1'b0;
         complete_d[head_q] = 1'b0;
      end
      if (retire_c[1]) begin
         valid_d[head_p1]    = 1'b0;
         complete_d[head_p1] = 1'b0;
      end
      head_d = head_q + IDX_W'(n_ret);

      if (disp_fire) begin
         for (int s = 0; s < 2; s++) begin
            if (rob.dispatch_valid[s]) begin
               valid_d[slot_idx[s]]    = 1'b1;
               complete_d[slot_idx[s]] = 1'b0;
               t_d[slot_idx[s]]        = rob.dispatch_T_idx[s];
               told_d[slot_idx[s]]     = rob.dispatch_Told_idx[s];
               fl_d[slot_idx[s]]       = rob.dispatch_FL_idx[s];
            end
         end
      end
      tail_d  = tail_q + IDX_W'(n_disp);
      count_d = count_q + CNT_W'(n_disp) - CNT_W'(n_ret);

      if (rob.rollback_en) begin
         // Entries further from head than the branch are younger and get squashed
         for (int i = 0; i < NUM_ROB; i++) begin
            dist_i = IDX_W'(i) - head_q;
            if (valid_q[i] && (dist_i > dist_rb)) begin
               valid_d[i]    = 1'b0;
               complete_d[i] = 1'b0;
            end
         end
         tail_d  = rob.rollback_rob_idx + IDX_W'(1);
         count_d = CNT_W'(dist_rb) + CNT_W'(1) - CNT_W'(n_ret);
      end
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         complete_q <= '0;
         for (int i = 0; i < NUM_ROB; i++) begin
            t_q[i]    <= ZERO_TAG;
            told_q[i] <= ZERO_TAG;
            fl_q[i]   <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         complete_q <= complete_d;
         t_q        <= t_d;
         told_q     <= told_d;
         fl_q       <= fl_d;
      end
   end
endmodule
